iter_shifter: RTL

ITER_SHIFTER -- requirements
Module: iter_shifter

---
 rtl/iter_shifter_pkg.sv | 22 ++
 rtl/iter_shifter_shift_step.sv | 24 ++
 rtl/iter_shifter.sv | 75 +++++++
 3 files changed

// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg: shift_op encodings, FSM state type and shift-op decode.
// ITER_SHIFTER_ROTATE_EN enables decoding of the rotate ops.
package iter_shifter_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_ASR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_shift(input logic [2:0] op);
`ifdef ITER_SHIFTER_ROTATE_EN
        return op inside {OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR};
`else
        return op inside {OP_LSL, OP_LSR, OP_ASR};
`endif
    endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step: one-bit combinational shift/rotate of W-bit data by op.
// Rotates exist only when ITER_SHIFTER_ROTATE_EN is defined.
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] data,
    input  logic [2:0]   op,
    output logic [W-1:0] result
);

    always_comb begin
        result = data;
        if (op == OP_LSL) result = {data[W-2:0], 1'b0};
        if (op == OP_LSR) result = {1'b0, data[W-1:1]};
        if (op == OP_ASR) result = {data[W-1], data[W-1:1]};
`ifdef ITER_SHIFTER_ROTATE_EN
        if (op == OP_ROL) result = {data[W-2:0], data[W-1]};
        if (op == OP_ROR) result = {data[0], data[W-1:1]};
`endif
    end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: iterative one-bit-per-cycle shifter with valid/ready handshakes.
// Define ITER_SHIFTER_ROTATE_EN to enable ROL/ROR; otherwise they behave as pass.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [2:0]           shift_op,
    input  logic [$clog2(W)-1:0] shift_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 busy
);

    localparam int AW = $clog2(W);

    state_t        state, state_n;
    logic [W-1:0]  res, res_n, step;
    logic [2:0]    op, op_n;
    logic [AW-1:0] cnt, cnt_n;

    shift_step #(.W(W)) u_step (
        .data   (res),
        .op     (op),
        .result (step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            res   <= '0;
            op    <= OP_PASS;
            cnt   <= '0;
        end else begin
            state <= state_n;
            res   <= res_n;
            op    <= op_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        res_n   = res;
        op_n    = op;
        cnt_n   = cnt;
        case (state)
            IDLE: if (in_valid) begin
                res_n   = in_data;
                op_n    = shift_op;
                cnt_n   = shift_amt;
                state_n = (is_shift(shift_op) && shift_amt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                res_n   = step;
                cnt_n   = cnt - 1'b1;
                state_n = (cnt == AW'(1)) ? DONE : SHIFT;
            end
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_data  = res;

endmodule
